// File: rtl/codec_pkg.sv
// Shared constants and types for the codec I2C control path.
package codec_pkg;

  localparam int         I2C_WORD_W      = 24;
  localparam logic [7:0] WM8731_I2C_ADDR = 8'h34;

  // Transaction status codes returned on rsp_err
  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_NACK    = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GAP
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past last_grant
// and wraps, so the most recent winner has the lowest priority.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  // Walk from the farthest candidate to the nearest; the nearest pending
  // request overwrites any earlier match, leaving a one-hot grant.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one i2c_controller among N_REQ requesters: round-robin accept,
// launch, retry on NACK, timeout, forced bus gap, per-requester status.
module i2c_bus_arbiter
  import codec_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 20000,
  parameter int GAP_CYC     = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*I2C_WORD_W-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [1:0]                    rsp_err,
  output logic                          busy,
  output logic [I2C_WORD_W-1:0]         i2c_data,
  output logic                          i2c_start,
  input  logic                          i2c_done,
  input  logic                          i2c_ack
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  arb_state_e              state;
  logic [IDX_W-1:0]        last_grant;
  logic [N_REQ-1:0]        owner;       // one-hot requester of the word in flight
  logic [RTY_W-1:0]        retry_cnt;
  logic                    retry_pend;  // GAP exits to START instead of IDLE
  logic [TMR_W-1:0]        tmr;
  logic [GAP_W-1:0]        gap_cnt;

  logic [N_REQ-1:0]        grant;
  logic [IDX_W-1:0]        grant_idx;
  logic [I2C_WORD_W-1:0]   win_word;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Select the winner's word with constant slices only.
  always_comb begin
    win_word = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) win_word = req_data[i*I2C_WORD_W +: I2C_WORD_W];
  end

  // Control FSM; every output is a flop so the controller sees clean levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_err    <= RSP_OK;
      busy       <= 1'b0;
      i2c_data   <= '0;
      i2c_start  <= 1'b0;
      last_grant <= IDX_W'(N_REQ - 1);  // requester 0 wins first
      owner      <= '0;
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
      tmr        <= '0;
      gap_cnt    <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_err   <= RSP_OK;
      i2c_start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            i2c_data   <= win_word;
            req_ready  <= grant;
            owner      <= grant;
            last_grant <= grant_idx;
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          i2c_start <= 1'b1;
          tmr       <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done in the same cycle as the timeout takes precedence.
          if (i2c_done) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
            if (i2c_ack) begin
              rsp_valid <= owner;
              rsp_err   <= RSP_OK;
            end else if (retry_cnt < RTY_MAX) begin
              retry_cnt  <= retry_cnt + 1'b1;
              retry_pend <= 1'b1;
            end else begin
              rsp_valid <= owner;
              rsp_err   <= RSP_NACK;
            end
          end else if (tmr == TMR_LAST) begin
            rsp_valid <= owner;
            rsp_err   <= RSP_TIMEOUT;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (retry_pend) begin
              retry_pend <= 1'b0;
              state      <= ST_START;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with a transaction-timeline model.
module tb_i2c_bus_arbiter;

  localparam int NR  = 2;
  localparam int MR  = 2;
  localparam int TO  = 40;
  localparam int GAP = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*24-1:0] req_data  = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [1:0]       rsp_err;
  logic             busy;
  logic [23:0]      i2c_data;
  logic             i2c_start;
  logic             i2c_done = 1'b0;
  logic             i2c_ack  = 1'b0;

  i2c_bus_arbiter #(
    .N_REQ(NR), .MAX_RETRY(MR), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .busy(busy), .i2c_data(i2c_data), .i2c_start(i2c_start),
    .i2c_done(i2c_done), .i2c_ack(i2c_ack)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: expected outputs for the current cycle ----------
  logic [NR-1:0] e_ready = '0;
  logic [NR-1:0] e_rsp   = '0;
  logic [1:0]    e_err   = '0;
  logic          e_busy  = 1'b0;
  logic          e_start = 1'b0;
  logic [23:0]   e_data  = '0;
  int            m_last;

  task automatic tick(output bit ab);
    @(posedge clk or posedge rst);
    ab = rst;
  endtask

  // One pass per accepted word: accept, launch attempts, report, gap.
  task automatic model_run();
    bit ab, got, again;
    int w, att, res;
    forever begin
      do begin
        tick(ab);
        if (ab) return;
      end while (req_valid == '0);
      w = 0; got = 0;
      for (int k = 1; k <= NR; k++)
        if (!got && req_valid[(m_last + k) % NR]) begin
          w = (m_last + k) % NR; got = 1;
        end
      m_last  = w;
      e_data  = req_data[w*24 +: 24];
      e_ready = '0;
      e_ready[w] = 1'b1;
      e_busy  = 1'b1;
      att = 0;
      do begin
        tick(ab);
        if (ab) return;
        e_ready = '0;
        e_start = 1'b1;
        res = -1;
        // edge k closes cycle start+k-1; no done by edge TO+1 is a timeout
        for (int k = 1; k <= TO + 1 && res < 0; k++) begin
          tick(ab);
          if (ab) return;
          e_start = 1'b0;
          if (i2c_done)        res = i2c_ack ? 0 : 1;
          else if (k == TO + 1) res = 2;
        end
        again = (res == 1) && (att < MR);
        if (!again) begin
          e_rsp[w] = 1'b1;
          e_err    = 2'(res);
        end
        for (int g = 0; g < GAP; g++) begin
          tick(ab);
          if (ab) return;
          e_rsp = '0;
          e_err = 2'b00;
        end
        att++;
      end while (again);
      e_busy = 1'b0;
    end
  endtask

  initial begin
    forever begin
      e_ready = '0; e_rsp = '0; e_err = '0; e_busy = 1'b0; e_start = 1'b0;
      m_last  = NR - 1;
      wait (rst == 1'b0);
      model_run();
    end
  end

  // Compare process: every cycle, DUT against model (or all-zero in reset).
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_outputs", {req_ready, rsp_valid, rsp_err, busy, i2c_start}, 0);
        chk("rst_data", i2c_data, 0);
      end else begin
        chk("req_ready", req_ready, e_ready);
        chk("rsp_valid", rsp_valid, e_rsp);
        chk("rsp_err",   rsp_err,   e_err);
        chk("busy",      busy,      e_busy);
        chk("i2c_start", i2c_start, e_start);
        if (e_busy) chk("i2c_data", i2c_data, e_data);
      end
    end
  end

  // Observation log for grant order and launch count.
  int grants[$];
  int n_starts = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int r = 0; r < NR; r++) if (req_ready[r]) grants.push_back(r);
        if (i2c_start) n_starts++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic wait_start(output int lat);
    bit found;
    found = 0;
    lat = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      lat++;
      for (int r = 0; r < NR; r++) if (req_ready[r]) req_valid[r] = 1'b0;
      if (i2c_start) found = 1;
    end
    chk("start_seen", found, 1);
  endtask

  task automatic pulse_done(input bit ack, input int d);
    repeat (d) @(posedge clk);
    #1 i2c_done = 1'b1; i2c_ack = ack;
    @(posedge clk);
    #1 i2c_done = 1'b0; i2c_ack = 1'b0;
  endtask

  task automatic wait_rsp(output logic [1:0] err, output logic [NR-1:0] who, output int cyc);
    bit found;
    found = 0; cyc = 0; err = 'x; who = '0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      cyc++;
      if (|rsp_valid) begin found = 1; err = rsp_err; who = rsp_valid; end
    end
    chk("rsp_seen", found, 1);
  endtask

  task automatic wait_idle();
    bit found;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1;
    end
    chk("idle_seen", found, 1);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ------------------------------------------
  initial begin
    int lat, cyc, n, s0, g0;
    bit stop;
    logic [1:0]    err;
    logic [NR-1:0] who;
    int ord[4];
    ord = '{0, 1, 0, 1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single word, ack
    @(posedge clk);
    #1 req_data[23:0] = 24'h340C07; req_valid[0] = 1'b1;
    wait_start(lat);
    chk("t1_start_lat", lat, 2);
    chk("t1_i2c_data", i2c_data, 24'h340C07);
    pulse_done(1'b1, 3);
    wait_rsp(err, who, cyc);
    chk("t1_rsp_err", err, 2'b00);
    chk("t1_rsp_who", who, 2'b01);
    n = 1; stop = 0;
    for (int i = 0; i < 100 && !stop; i++) begin
      @(negedge clk);
      if (busy) n++; else stop = 1;
    end
    chk("t1_gap_busy", n, GAP);

    // 2: simultaneous requests after reset, two rounds
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    g0 = grants.size();
    req_data[23:0] = 24'h340E05; req_data[47:24] = 24'h340A12;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_start(lat);
      if (i == 1) req_valid = 2'b11;
      pulse_done(1'b1, 2);
      wait_rsp(err, who, cyc);
      chk("t2_rsp_err", err, 2'b00);
    end
    wait_idle();
    chk("t2_ngrants", grants.size() - g0, 4);
    for (int k = 0; k < 4; k++)
      chk("t2_order", (grants.size() > g0 + k) ? grants[g0 + k] : 99, ord[k]);

    // 3: NACK every attempt
    s0 = n_starts;
    @(posedge clk);
    #1 req_data[23:0] = 24'h341E00; req_valid[0] = 1'b1;
    for (int a = 0; a <= MR; a++) begin
      wait_start(lat);
      pulse_done(1'b0, 4);
    end
    wait_rsp(err, who, cyc);
    chk("t3_rsp_err", err, 2'b01);
    wait_idle();
    chk("t3_starts", n_starts - s0, 3);

    // 4: NACK then ack, plus a stray done during GAP
    s0 = n_starts;
    @(posedge clk);
    #1 req_data[47:24] = 24'h340812; req_valid[1] = 1'b1;
    wait_start(lat);
    pulse_done(1'b0, 2);
    wait_start(lat);
    pulse_done(1'b1, 2);
    wait_rsp(err, who, cyc);
    chk("t4_rsp_err", err, 2'b00);
    chk("t4_rsp_who", who, 2'b10);
    pulse_done(1'b0, 1);
    wait_idle();
    chk("t4_starts", n_starts - s0, 2);

    // 5a: timeout
    @(posedge clk);
    #1 req_data[23:0] = 24'h340C00; req_valid[0] = 1'b1;
    wait_start(lat);
    wait_rsp(err, who, cyc);
    chk("t5_timeout_err", err, 2'b10);
    chk("t5_timeout_cyc", cyc, TO + 1);
    wait_idle();

    // 5b: done coincident with timeout
    @(posedge clk);
    #1 req_data[47:24] = 24'h340C01; req_valid[1] = 1'b1;
    wait_start(lat);
    pulse_done(1'b1, TO);
    wait_rsp(err, who, cyc);
    chk("t5_coincident_err", err, 2'b00);
    wait_idle();

    // 6: reset during WAIT, then normal service
    @(posedge clk);
    #1 req_data[23:0] = 24'h340F01; req_valid[0] = 1'b1;
    wait_start(lat);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_rsp", rsp_valid, 0);
    chk("t6_start", i2c_start, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    req_data[47:24] = 24'h340A55; req_valid[1] = 1'b1;
    wait_start(lat);
    chk("t6_lat", lat, 2);
    chk("t6_i2c_data", i2c_data, 24'h340A55);
    pulse_done(1'b1, 1);
    wait_rsp(err, who, cyc);
    chk("t6_rsp_err", err, 2'b00);
    chk("t6_rsp_who", who, 2'b10);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
